// File: rtl/mem_code_pkg.sv
// mem_code_pkg: shared definitions for the memory-code chip generator.
// FSM encodings and the sync code ROM read latency.
package mem_code_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_FILL = 2'd1;
    localparam state_t S_RUN  = 2'd2;

    localparam int unsigned ROM_LAT = 1;

endpackage

// File: rtl/mem_code_wordbuf.sv
// mem_code_wordbuf: current/next ROM word double buffer.
// Selects the chip bit and forwards a just-landing word on a switch.
import mem_code_pkg::*;

module mem_code_wordbuf #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  swap,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [IDX_WIDTH-1:0]  sel,
    output logic                  cur_valid,
    output logic                  next_avail,
    output logic                  sel_bit,
    output logic                  next_msb
);

    logic [DATA_WIDTH-1:0] cur_word;
    logic [DATA_WIDTH-1:0] next_word;
    logic                  next_valid;

    // next word is usable if held, or landing now while cur is occupied
    always_comb begin
        next_avail = next_valid | (load & cur_valid);
        next_msb   = next_valid ? next_word[DATA_WIDTH-1]
                                : rdata[DATA_WIDTH-1];
        sel_bit    = cur_word[~sel];
    end

    // landing words fill cur first, then next; a swap promotes next
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cur_word   <= '0;
            next_word  <= '0;
            cur_valid  <= 1'b0;
            next_valid <= 1'b0;
        end else if (clear) begin
            cur_valid  <= 1'b0;
            next_valid <= 1'b0;
        end else if (swap) begin
            next_valid <= 1'b0;
            if (next_valid) begin
                cur_word  <= next_word;
                cur_valid <= 1'b1;
            end else if (load && cur_valid) begin
                cur_word  <= rdata;
                cur_valid <= 1'b1;
            end else begin
                cur_valid <= 1'b0;
            end
        end else if (load) begin
            if (!cur_valid) begin
                cur_word  <= rdata;
                cur_valid <= 1'b1;
            end else begin
                next_word  <= rdata;
                next_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_code_gen.sv
// mem_code_gen: code chip generator fed from the sync code ROM.
// FSM, chip/bit counters, prefetch address generator, underrun flag.
import mem_code_pkg::*;

module mem_code_gen #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  enable,
    input  logic                  init,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  code_length,
    input  logic                  phase_step,
    output logic                  rom_rd,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    output logic                  code_bit,
    output logic                  code_valid,
    output logic                  epoch,
    output logic                  underrun
);

    localparam int IDX_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [LEN_WIDTH:0] DW = (LEN_WIDTH+1)'(DATA_WIDTH);

    state_t                state;
    logic                  fill2;
    logic [LEN_WIDTH-1:0]  chip_cnt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  req_base;
    logic [ADDR_WIDTH-1:0] start_q;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [IDX_WIDTH-1:0]  bit_idx;
    logic [ROM_LAT-1:0]    rd_pipe;

    logic                  load;
    logic                  take;
    logic                  step;
    logic                  wrap;
    logic                  swap;
    logic                  recover;
    logic                  issue;
    logic                  last;
    logic                  take_last;
    logic [LEN_WIDTH:0]    base_end;
    logic                  cur_valid;
    logic                  next_avail;
    logic                  sel_bit;
    logic                  next_msb;

    // step/switch decode and the word-after-request address rule
    always_comb begin
        load      = rd_pipe[ROM_LAT-1] & enable;
        take      = enable & init;
        step      = enable & ~take & phase_step & code_valid;
        wrap      = chip_cnt == len_q - 1'b1;
        swap      = step & (wrap | (&bit_idx));
        recover   = enable & ~take & (state == S_RUN)
                  & load & ~cur_valid;
        issue     = enable & ~take
                  & (((state == S_FILL) & fill2)
                  | (swap & next_avail) | recover);
        base_end  = {1'b0, req_base} + DW;
        last      = base_end >= {1'b0, len_q};
        take_last = DW >= {1'b0, code_length};
    end

    mem_code_wordbuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wordbuf (
        .clk       (clk),
        .rst_b     (rst_b),
        .clear     (take),
        .load      (load),
        .swap      (swap),
        .rdata     (rom_rdata),
        .sel       (bit_idx + 1'b1),
        .cur_valid (cur_valid),
        .next_avail(next_avail),
        .sel_bit   (sel_bit),
        .next_msb  (next_msb)
    );

    // read pipeline; reads issued before init or disable are dropped
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_pipe <= '0;
        end else if (take || !enable) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= ROM_LAT'({rd_pipe, rom_rd});
        end
    end

    // FSM, counters, ROM requests and chip output
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= S_IDLE;
            fill2      <= 1'b0;
            chip_cnt   <= '0;
            len_q      <= '0;
            req_base   <= '0;
            start_q    <= '0;
            req_addr   <= '0;
            bit_idx    <= '0;
            rom_rd     <= 1'b0;
            rom_addr   <= '0;
            code_bit   <= 1'b0;
            code_valid <= 1'b0;
            epoch      <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            rom_rd <= issue | take;
            epoch  <= 1'b0;
            if (issue) begin
                rom_addr <= req_addr;
                req_addr <= last ? start_q : req_addr + 1'b1;
                req_base <= last ? '0 : base_end[LEN_WIDTH-1:0];
            end
            if (!enable) begin
                state      <= S_IDLE;
                code_valid <= 1'b0;
            end else if (take) begin
                state      <= S_FILL;
                fill2      <= 1'b1;
                rom_addr   <= start_addr;
                start_q    <= start_addr;
                len_q      <= code_length;
                req_addr   <= take_last ? start_addr
                                        : start_addr + 1'b1;
                req_base   <= take_last ? '0 : DW[LEN_WIDTH-1:0];
                chip_cnt   <= '0;
                bit_idx    <= '0;
                underrun   <= 1'b0;
                code_valid <= 1'b0;
            end else begin
                fill2 <= 1'b0;
                if (state == S_FILL && load && cur_valid) begin
                    state <= S_RUN;
                end
                if (load && !cur_valid && state != S_IDLE) begin
                    code_valid <= 1'b1;
                    code_bit   <= rom_rdata[DATA_WIDTH-1];
                end
                if (step) begin
                    epoch    <= wrap;
                    chip_cnt <= wrap ? '0 : chip_cnt + 1'b1;
                    if (swap) begin
                        bit_idx <= '0;
                        if (next_avail) begin
                            code_bit <= next_msb;
                        end else begin
                            underrun   <= 1'b1;
                            code_valid <= 1'b0;
                        end
                    end else begin
                        bit_idx  <= bit_idx + 1'b1;
                        code_bit <= sel_bit;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_code_gen.sv
// tb_mem_code_gen: scoreboard bench for mem_code_gen.
// Driver queues expected reads/chips; a monitor pops and compares.
module tb_mem_code_gen;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        enable;
    logic        init;
    logic [9:0]  start_addr;
    logic [13:0] code_length;
    logic        phase_step;
    logic        rom_rd;
    logic [9:0]  rom_addr;
    logic [31:0] rom_rdata = '0;
    logic        code_bit;
    logic        code_valid;
    logic        epoch;
    logic        underrun;

    logic [31:0] rom [0:1023];
    logic [9:0]  addr_q [$];
    logic [1:0]  chip_q [$];

    int          n_chk = 0;
    int          n_err = 0;
    int          ep_cnt = 0;
    bit          mon_en = 1'b0;
    logic        step_acc = 1'b0;
    logic        cv_prev = 1'b0;
    logic [9:0]  m_start;
    int          m_len;
    int          m_k;

    mem_code_gen dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .enable     (enable),
        .init       (init),
        .start_addr (start_addr),
        .code_length(code_length),
        .phase_step (phase_step),
        .rom_rd     (rom_rd),
        .rom_addr   (rom_addr),
        .rom_rdata  (rom_rdata),
        .code_bit   (code_bit),
        .code_valid (code_valid),
        .epoch      (epoch),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // sync code ROM with one cycle read latency
    always @(posedge clk) begin
        if (rom_rd) rom_rdata <= rom[rom_addr];
    end

    // remember whether the DUT should accept a step at this edge
    always @(posedge clk) begin
        step_acc <= phase_step & code_valid & ~init & enable & rst_b;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic ebit(input int k);
        logic [9:0]  a;
        logic [31:0] w;
        a = m_start + 10'(k / 32);
        w = rom[a];
        return w[31 - (k % 32)];
    endfunction

    function automatic logic [9:0] eaddr(input int w);
        int nw;
        nw = (m_len - 1) / 32 + 1;
        if (w + 1 >= nw) return m_start;
        return m_start + 10'(w + 1);
    endfunction

    // monitor: compare every ROM read and every presented chip
    always @(negedge clk) begin
        logic       pres;
        logic [1:0] e;
        pres = code_valid && (step_acc || !cv_prev);
        if (mon_en) begin
            if (rom_rd) begin
                if (addr_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rd_extra: read %0h, none expected",
                             rom_addr);
                end else begin
                    chk("rom_addr", 32'(rom_addr),
                        32'(addr_q.pop_front()));
                end
            end
            if (pres) begin
                if (chip_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL chip_extra: chip %0b, none expected",
                             code_bit);
                end else begin
                    e = chip_q.pop_front();
                    chk("chip_bit_epoch", 32'({code_bit, epoch}), 32'(e));
                end
            end else if (epoch) begin
                n_chk++;
                n_err++;
                $display("FAIL epoch_stray: epoch=1 expected 0");
            end
        end
        if (epoch) ep_cnt++;
        cv_prev = code_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [9:0] a, input int l,
                           input bit with_step);
        init = 1'b1;
        start_addr = a;
        code_length = 14'(l);
        phase_step = with_step;
        tick();
        init = 1'b0;
        phase_step = 1'b0;
        m_start = a;
        m_len = l;
        m_k = 0;
        addr_q.push_back(a);
        addr_q.push_back(eaddr(0));
        chip_q.push_back({ebit(0), 1'b0});
        tick();
        chk("cv_n2", 32'(code_valid), 0);
        tick();
        chk("cv_n3", 32'(code_valid), 1);
        chk("bit_n3", 32'(code_bit), 32'(ebit(0)));
        tick();
    endtask

    task automatic step(input int gap);
        phase_step = 1'b1;
        tick();
        phase_step = 1'b0;
        m_k = (m_k + 1) % m_len;
        chip_q.push_back({ebit(m_k), m_k == 0});
        if (m_k % 32 == 0) addr_q.push_back(eaddr(m_k / 32));
        repeat (gap - 1) tick();
    endtask

    task automatic drained(input string nm);
        repeat (3) tick();
        chk({nm, "_addr_q"}, 32'(addr_q.size()), 0);
        chk({nm, "_chip_q"}, 32'(chip_q.size()), 0);
    endtask

    initial begin
        logic [8:0] hand;
        bit         drop;
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 32'h9E37_79B9 * 32'(i + 1);
        end
        rom[10'h010] = 32'hA5A5_0000;
        hand = 9'b1_0100_1011;
        rst_b = 1'b0;
        enable = 1'b1;
        init = 1'b0;
        phase_step = 1'b0;
        start_addr = '0;
        code_length = '0;
        repeat (2) tick();
        chk("rst_rd", 32'(rom_rd), 0);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_bit", 32'(code_bit), 0);
        chk("rst_valid", 32'(code_valid), 0);
        chk("rst_epoch", 32'(epoch), 0);
        chk("rst_underrun", 32'(underrun), 0);
        rst_b = 1'b1;
        mon_en = 1'b1;
        repeat (3) tick();
        chk("idle_valid", 32'(code_valid), 0);

        // first word A5A5_0000, len 100, slow steps
        do_init(10'h010, 100, 1'b0);
        chk("s1_chip0", 32'(code_bit), 32'(hand[8]));
        for (int i = 1; i <= 8; i++) begin
            step(4);
            chk("s1_hand", 32'(code_bit), 32'(hand[8 - i]));
        end
        ep_cnt = 0;
        for (int i = 9; i <= 100; i++) step(4);
        chk("s2_wrap_bit", 32'(code_bit), 1);
        drained("s2");
        chk("s2_epochs", 32'(ep_cnt), 1);

        // init together with a step at chip 57
        do_init(10'h010, 100, 1'b0);
        for (int i = 0; i < 57; i++) step(1);
        do_init(10'h010, 100, 1'b1);
        for (int i = 0; i < 5; i++) step(1);
        drained("s5");

        // short code, one word reused every epoch
        ep_cnt = 0;
        do_init(10'h030, 20, 1'b0);
        for (int i = 0; i < 45; i++) step(1);
        drained("s4");
        chk("s4_epochs", 32'(ep_cnt), 2);

        // len 33 stepped every cycle must underrun
        do_init(10'h020, 33, 1'b0);
        for (int i = 0; i < 30; i++) step(1);
        drained("s3a");
        mon_en = 1'b0;
        drop = 1'b0;
        phase_step = 1'b1;
        repeat (8) begin
            tick();
            if (!code_valid) drop = 1'b1;
        end
        phase_step = 1'b0;
        repeat (4) tick();
        chk("s3_underrun", 32'(underrun), 1);
        chk("s3_drop", 32'(drop), 1);
        addr_q.delete();
        chip_q.delete();
        mon_en = 1'b1;
        ep_cnt = 0;
        do_init(10'h020, 33, 1'b0);
        chk("s3_clear", 32'(underrun), 0);
        for (int i = 0; i < 40; i++) step(3);
        drained("s3b");
        chk("s3_no_underrun", 32'(underrun), 0);
        chk("s3_epochs", 32'(ep_cnt), 1);

        // reset in the middle of the fill
        mon_en = 1'b0;
        init = 1'b1;
        start_addr = 10'h010;
        code_length = 14'd100;
        tick();
        init = 1'b0;
        tick();
        rst_b = 1'b0;
        #1;
        chk("s6_rd", 32'(rom_rd), 0);
        chk("s6_addr", 32'(rom_addr), 0);
        chk("s6_bit", 32'(code_bit), 0);
        chk("s6_valid", 32'(code_valid), 0);
        chk("s6_epoch", 32'(epoch), 0);
        chk("s6_underrun", 32'(underrun), 0);
        tick();
        rst_b = 1'b1;
        addr_q.delete();
        chip_q.delete();
        mon_en = 1'b1;
        repeat (10) tick();
        chk("s6_idle_valid", 32'(code_valid), 0);
        chk("s6_idle_rd", 32'(rom_rd), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
